axi_read_arbiter: RTL

- Single AXI4 read master shared by instruction fetch (IF) and data load (MEM).
- Arbitrates between the two requesters and runs one single-beat read at a time.
- Produces stallreq_from_if, stallreq_from_mem and axi_read_state for the pipeline controller.
- Consumes the stall vector and flush back from the pipeline controller.

---
 rtl/axi_read_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read master between instruction fetch (IF)
// and data load (MEM). It runs one single-beat read at a time, and MEM has
// priority over IF. Each requester's result is held in a done flag until its
// pipeline stage advances.
// Optional build macro AXI_RD_TIMEOUT_EN adds an R-channel watchdog that
// forces completion and pulses bus_err; without it, bus_err is tied low.
module axi_read_arbiter #(
   parameter logic [3:0]  IF_ARID        = 4'h0,
   parameter logic [3:0]  MEM_ARID       = 4'h1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_size,
   output logic [31:0] mem_rdata,
   input  logic [5:0]  stall,
   input  logic        flush,
   output logic        stallreq_from_if,
   output logic        stallreq_from_mem,
   output logic [1:0]  axi_read_state,
   output logic        bus_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [2:0] {
      IDLE, AR_IF, R_IF, DONE_IF, AR_MEM, R_MEM, DONE_MEM
   } state_t;

   state_t      state_q, state_d;
   logic        if_done_q, if_done_d;
   logic        mem_done_q, mem_done_d;
   logic        discard_q, discard_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [3:0]  ar_id_q, ar_id_d;
   logic [2:0]  ar_size_q, ar_size_d;
   logic        in_r;
   logic        r_beat;
   logic        timeout_hit;
   logic [31:0] r_word;

   // rid and rresp are deliberately not interpreted; the data is used as-is
   logic unused_ok;
   assign unused_ok = ^{rid, rresp, stall[5], stall[3:2], stall[0], TIMEOUT_CYCLES};

   assign in_r   = (state_q == R_IF) || (state_q == R_MEM);
   assign r_beat = in_r && rvalid && rlast;
   assign r_word = r_beat ? rdata : 32'h0;

`ifdef AXI_RD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          late_q, late_d;

   // Watchdog counts R-phase cycles from zero; a beat that never came is tracked as late
   always_comb begin
      cnt_d       = in_r ? cnt_q + CW'(1) : '0;
      timeout_hit = in_r && !r_beat && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      late_d      = late_q;
      if (timeout_hit)
         late_d = 1'b1;
      else if ((state_q == IDLE) && rvalid && rlast)
         late_d = 1'b0;
   end

   // Watchdog state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         late_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         late_q <= late_d;
      end
   end

   assign bus_err = timeout_hit;
   assign rready  = in_r || ((state_q == IDLE) && late_q);
`else
   assign timeout_hit = 1'b0;
   assign bus_err     = 1'b0;
   assign rready      = in_r;
`endif

   // Next-state, done-flag bookkeeping and read-data capture
   always_comb begin
      state_d     = state_q;
      if_done_d   = if_done_q;
      mem_done_d  = mem_done_q;
      discard_d   = discard_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      ar_addr_d   = ar_addr_q;
      ar_id_d     = ar_id_q;
      ar_size_d   = ar_size_q;
      // A held result is released once its stage advances; a set later in this block wins
      if (!stall[1]) if_done_d  = 1'b0;
      if (!stall[4]) mem_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!flush) begin
               if (mem_req && !mem_done_q) begin
                  state_d   = AR_MEM;
                  ar_addr_d = mem_addr;
                  ar_id_d   = MEM_ARID;
                  ar_size_d = {1'b0, mem_size};
               end else if (if_req && !if_done_q) begin
                  state_d   = AR_IF;
                  ar_addr_d = {if_addr[31:2], 2'b00};
                  ar_id_d   = IF_ARID;
                  ar_size_d = 3'd2;
               end
            end
         end
         AR_IF, AR_MEM: begin
            // arvalid stays up until accepted, even if the request is flushed
            if (flush) discard_d = 1'b1;
            if (arready) state_d = (state_q == AR_IF) ? R_IF : R_MEM;
         end
         R_IF, R_MEM: begin
            if (r_beat || timeout_hit) begin
               if (discard_q || flush) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end else if (state_q == R_IF) begin
                  if_rdata_d = r_word;
                  if_done_d  = 1'b1;
                  state_d    = timeout_hit ? IDLE : DONE_IF;
               end else begin
                  mem_rdata_d = r_word;
                  mem_done_d  = 1'b1;
                  state_d     = timeout_hit ? IDLE : DONE_MEM;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         DONE_IF, DONE_MEM: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         if_done_d  = 1'b0;
         mem_done_d = 1'b0;
      end
   end

   // Control state and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         discard_q   <= 1'b0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         discard_q   <= discard_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // AR payload registers; only meaningful while arvalid is high
   always_ff @(posedge clk) begin
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      ar_size_q <= ar_size_d;
   end

   // Busy-state report for the pipeline controller
   always_comb begin
      axi_read_state = 2'b00;
      case (state_q)
         AR_IF, R_IF:   axi_read_state = 2'b01;
         AR_MEM, R_MEM: axi_read_state = 2'b10;
         default:       axi_read_state = 2'b00;
      endcase
   end

   assign stallreq_from_if  = if_req & ~if_done_q;
   assign stallreq_from_mem = mem_req & ~mem_done_q;
   assign if_rdata          = if_rdata_q;
   assign mem_rdata         = mem_rdata_q;
   assign arvalid           = (state_q == AR_IF) || (state_q == AR_MEM);
   assign araddr            = ar_addr_q;
   assign arid              = ar_id_q;
   assign arsize            = ar_size_q;
   assign arlen             = 8'd0;
   assign arburst           = 2'b01;

endmodule
